// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment driver.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SEG_W      = 8;
   localparam int IDX_W      = 2;

   localparam logic [SEG_W-1:0]      SEG_OFF = 8'hFF;
   localparam logic [NUM_DIGITS-1:0] SEL_OFF = 4'hF;

   typedef logic [IDX_W-1:0] idx_t;

   // Active-low one-hot select for digit i.
   function automatic logic [NUM_DIGITS-1:0] digit_sel(input idx_t i);
      return ~(NUM_DIGITS'(1) << i);
   endfunction

endpackage

// File: rtl/seg7_refresh_tick.sv
// Slot counter and digit index for the scan driver; flags the last cycle of a frame.
module seg7_refresh_tick
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = $clog2(REFRESH_DIV)
)(
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             enable,
   output logic [CNT_W-1:0] cnt,
   output logic [IDX_W-1:0] idx,
   output logic             frame_wrap
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   logic slot_wrap;

   assign slot_wrap  = (cnt == CNT_MAX);
   assign frame_wrap = enable && slot_wrap && (idx == IDX_MAX);

   // Disabled scan parks at digit 0, slot start, so re-enable begins a fresh frame.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (!enable) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_wrap) begin
         cnt <= '0;
         idx <= idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/seg7_scan_drv.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous word update.
// Optional brightness dimming is built when SEG7_DIM_EN is defined.
module seg7_scan_drv
   import seg7_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000
)(
   input  logic        sysclk,
   input  logic        rst_n,
   input  logic [31:0] seg_word,
   input  logic        load,
   input  logic        enable,
   input  logic [3:0]  duty,
   output logic [3:0]  LEDSEL,
   output logic [7:0]  LEDOUT,
   output logic        pending,
   output logic        frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic             frame_wrap;
   logic [31:0]      active;
   logic [31:0]      pending_word;
   logic [31:0]      xfer_word;
   logic             xfer;
   logic             blank;
   logic             lit;

   seg7_refresh_tick #(
      .REFRESH_DIV (REFRESH_DIV),
      .CNT_W       (CNT_W)
   ) u_tick (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cnt        (cnt),
      .idx        (idx),
      .frame_wrap (frame_wrap)
   );

   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign blank = 1'b0;
      end else begin : g_blank
         assign blank = (cnt < CNT_W'(BLANK_CYC));
      end
   endgenerate

`ifdef SEG7_DIM_EN
   logic [3:0] dim_cnt;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) dim_cnt <= '0;
      else        dim_cnt <= dim_cnt + 4'd1;
   end

   assign lit = (dim_cnt <= duty);
`else
   logic unused_duty;
   assign unused_duty = ^duty;
   assign lit         = 1'b1;
`endif

   // A load landing on the transfer cycle bypasses the pending register.
   assign xfer      = (frame_wrap || !enable) && (pending || load);
   assign xfer_word = load ? seg_word : pending_word;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         active       <= '1;
         pending_word <= '1;
         pending      <= 1'b0;
         LEDSEL       <= SEL_OFF;
         LEDOUT       <= SEG_OFF;
         frame_done   <= 1'b0;
      end else begin
         if (load) pending_word <= seg_word;

         if (xfer) begin
            active  <= xfer_word;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end

         if (!enable || blank || !lit) begin
            LEDSEL <= SEL_OFF;
            LEDOUT <= SEG_OFF;
         end else begin
            LEDSEL <= digit_sel(idx);
            LEDOUT <= active[{idx, 3'b000} +: SEG_W];
         end

         frame_done <= frame_wrap;
      end
   end

endmodule

// File: doc/seg7_scan_drv.md
SEG7_SCAN_DRV -- requirements
Module: seg7_scan_drv

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: sysclk cycles per digit slot, legal range 4..2^20.
REQ-002 Parameter BLANK_CYC, default 1000: inter-digit blanking cycles at the start of each slot, legal range 0..REFRESH_DIV-2.
REQ-003 Port sysclk, input, 1: sole clock, all state on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port seg_word, input, 32: digit d segment pattern in bits [8d+7:8d], in active-low LEDOUT polarity (bit 7 = dp).
REQ-006 Port load, input, 1: single-cycle strobe that captures seg_word into the pending register.
REQ-007 Port enable, input, 1: scan enable; low forces the display dark.
REQ-008 Port duty, input, 4: brightness level, effective only under SEG7_DIM_EN.
REQ-009 Port LEDSEL, output, 4: active-low digit select, one-hot-low when lit.
REQ-010 Port LEDOUT, output, 8: active-low segments of the selected digit.
REQ-011 Port pending, output, 1: high while a loaded word awaits its frame boundary.
REQ-012 Port frame_done, output, 1: one-cycle pulse at each frame end.

Function
REQ-013 Slot counter cnt SHALL count 0..REFRESH_DIV-1 and wrap; digit index idx (2 bits) SHALL increment on cnt wrap, 3 wrapping to 0.
REQ-014 All outputs SHALL be registered, reflecting cnt/idx/active state of the previous cycle (latency 1).
REQ-015 When cnt < BLANK_CYC: LEDSEL = 4'hF and LEDOUT = 8'hFF.
REQ-016 Otherwise: LEDSEL = ~(4'b1 << idx) and LEDOUT = active[8*idx+7 : 8*idx].
REQ-017 load SHALL write pending_word <= seg_word and set pending; a load while pending is high overwrites the word (last load wins).
REQ-018 On frame wrap (idx==3, cnt==REFRESH_DIV-1), if pending: active <= pending_word and pending cleared; a load in that same cycle SHALL be the word transferred.
REQ-019 frame_done SHALL pulse exactly once per frame, in the output cycle following the frame-wrap cycle.
REQ-020 enable low SHALL hold cnt=0 and idx=0, force LEDSEL=4'hF and LEDOUT=8'hFF, suppress frame_done, and still accept load; a pending transfer SHALL occur immediately on the enable-low cycle.
REQ-021 On the enable rise, scanning SHALL restart at digit 0, cnt 0.

Reset
REQ-022 While rst_n is low: cnt=0, idx=0, active=32'hFFFF_FFFF, pending_word=32'hFFFF_FFFF, pending=0, LEDSEL=4'hF, LEDOUT=8'hFF, frame_done=0, dim counter=0.
REQ-023 Reset assertion mid-slot or mid-frame SHALL blank the outputs asynchronously; release SHALL start at digit 0.

Configuration
REQ-024 With SEG7_DIM_EN defined: a 4-bit dim counter free-runs each cycle, and the non-blank digit is lit only when dim counter <= duty; duty=15 gives full brightness and duty=0 gives 1/16 brightness.
REQ-025 With SEG7_DIM_EN undefined: the duty port is present but ignored, no dim counter is built, and behaviour equals duty=15.

Structure
REQ-026 Package seg7_pkg SHALL hold NUM_DIGITS=4, SEG_W=8, IDX_W=2, SEG_OFF=8'hFF, SEL_OFF=4'hF and the idx typedef.
REQ-027 The slot counter and wrap/frame-tick logic SHALL be sub-module seg7_refresh_tick; data path and registers stay in seg7_scan_drv.

Verification (bench: REFRESH_DIV=8, BLANK_CYC=2)
REQ-028 Reset release, no load -> LEDSEL cycles E,D,B,7 per 8-cycle slot; LEDOUT=FF throughout; first 2 cycles of each slot have LEDSEL=F.
REQ-029 load seg_word=32'hC0F9A4B0 mid-frame -> pending=1; digit 0 shows FF until the next frame; then digits 0..3 show B0, A4, F9, C0 and pending=0.
REQ-030 Two loads (11223344, then 55667788) within one frame -> only 55667788 is displayed; load coinciding with the frame-wrap cycle is displayed in the next frame.
REQ-031 Drive the outputs into _7seg_cap for 2 frames after loading 32'h8899AABB -> captured LEDOUT_all == 32'h8899AABB (round trip).
REQ-032 enable low for 20 cycles mid-digit-2 -> LEDSEL=F, no frame_done; on re-enable, the digit-0 slot starts with 2 blank cycles.
REQ-033 SEG7_DIM_EN, duty=3 -> per slot, the lit cycles equal the count of non-blank cycles where dim counter <= 3; rst_n pulse mid-slot -> outputs go F/FF in the same cycle.
